// File: rtl/dog_anim_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dog_anim_pkg
//  Description : Shared types and constants for the dog walk-animation
//                sequencer (FSM states, command encoding, colour width).
//  Revision    : 1.0  initial release
// ============================================================================
package dog_anim_pkg;

   localparam int RGB_W = 12;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } anim_state_t;

   typedef enum logic [1:0] {
      CMD_NONE  = 2'd0,
      CMD_START = 2'd1,
      CMD_STOP  = 2'd2,
      CMD_HOME  = 2'd3
   } anim_cmd_t;

   // Collapse the three request strobes into one command; home beats stop beats start.
   function automatic anim_cmd_t encode_cmd(input logic start, input logic stop, input logic home);
      anim_cmd_t cmd;
      if (home)       cmd = CMD_HOME;
      else if (stop)  cmd = CMD_STOP;
      else if (start) cmd = CMD_START;
      else            cmd = CMD_NONE;
      return cmd;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vsync_tick.sv
`default_nettype none
// ============================================================================
//  Module      : vsync_tick
//  Description : Detects the falling edge of the active-low vertical sync and
//                produces a one-cycle frame tick.
//  Revision    : 1.0  initial release
// ============================================================================
module vsync_tick (
   input  logic vga_clk_i,
   input  logic reset_i,
   input  logic vs_i,
   output logic tick_o
);

   logic vs_q;

   // Delay vs by one pixel clock; idles high so reset never fakes an edge.
   always_ff @(posedge vga_clk_i) begin
      if (reset_i) vs_q <= 1'b1;
      else         vs_q <= vs_i;
   end

   assign tick_o = vs_q & ~vs_i;

endmodule
`default_nettype wire

// File: rtl/dog_anim_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : dog_anim_sequencer
//  Description : Selects one of NUM_FRAMES sprite colour streams per video
//                frame and steps the walk animation on vsync boundaries, so a
//                frame never mixes two sprites. Drives the final RGB pins.
//  Revision    : 1.0  initial release
// ============================================================================
module dog_anim_sequencer
   import dog_anim_pkg::*;
#(
   parameter  int NUM_FRAMES     = 6,
   parameter  int TICKS_PER_STEP = 6,
   parameter  bit PING_PONG      = 1'b0,
   localparam int IDX_W          = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
   input  logic                          vga_clk_i,
   input  logic                          reset_i,
   input  logic                          vs_i,
   input  logic                          start_i,
   input  logic                          stop_i,
   input  logic                          home_i,
   input  logic [NUM_FRAMES*RGB_W-1:0]   rgb_in_i,
   output logic [3:0]                    red_o,
   output logic [3:0]                    green_o,
   output logic [3:0]                    blue_o,
   output logic [IDX_W-1:0]              frame_idx_o,
   output logic                          step_o,
   output logic                          running_o
);

   localparam int              CNT_W    = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_STEP - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_FRAMES - 1);
   localparam logic [IDX_W-1:0] IDX_PEN  = IDX_W'(NUM_FRAMES - 2);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   anim_state_t      state_q,   state_d;
   anim_cmd_t        pending_q, pending_d;
   anim_cmd_t        req;
   logic [IDX_W-1:0] idx_q,     idx_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic             dir_down_q, dir_down_d;
   logic             step_q,    step_d;
   logic [RGB_W-1:0] rgb_q;
   logic [IDX_W-1:0] adv_idx;
   logic             adv_dir_down;
   logic             tick;
   logic [RGB_W-1:0] slice [NUM_FRAMES];

   vsync_tick u_vsync_tick (
      .vga_clk_i (vga_clk_i),
      .reset_i   (reset_i),
      .vs_i      (vs_i),
      .tick_o    (tick)
   );

   generate
      for (genvar k = 0; k < NUM_FRAMES; k++) begin : g_slice
         assign slice[k] = rgb_in_i[k*RGB_W +: RGB_W];
      end
   endgenerate

   assign req = encode_cmd(start_i, stop_i, home_i);

   // Next sprite frame (and direction) if the animation advances this tick.
   always_comb begin
      adv_idx      = idx_q;
      adv_dir_down = dir_down_q;
      if (NUM_FRAMES == 1) begin
         adv_idx = '0;
      end else if (!PING_PONG) begin
         adv_idx = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else if (!dir_down_q) begin
         if (idx_q == IDX_LAST) begin
            adv_dir_down = 1'b1;
            adv_idx      = IDX_PEN;
         end else begin
            adv_idx = idx_q + 1'b1;
         end
      end else begin
         if (idx_q == '0) begin
            adv_dir_down = 1'b0;
            adv_idx      = IDX_ONE;
         end else begin
            adv_idx = idx_q - 1'b1;
         end
      end
   end

   // Command latch and sequencer next state; everything moves only on a tick.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      dir_down_d = dir_down_q;
      step_d     = 1'b0;

      // A tick consumes the old pending command; a request in that same cycle waits for the next tick.
      if (tick)                 pending_d = req;
      else if (req != CMD_NONE) pending_d = req;
      else                      pending_d = pending_q;

      if (tick) begin
         case (state_q)
            IDLE: begin
               idx_d = '0;
               if (pending_q == CMD_START) begin
                  state_d = RUN;
                  cnt_d   = '0;
               end
            end
            RUN: begin
               if (pending_q == CMD_HOME) begin
                  state_d    = IDLE;
                  idx_d      = '0;
                  cnt_d      = '0;
                  dir_down_d = 1'b0;
                  step_d     = (idx_q != '0);
               end else if (pending_q == CMD_STOP) begin
                  state_d = HOLD;
               end else if (cnt_q == CNT_LAST) begin
                  cnt_d      = '0;
                  idx_d      = adv_idx;
                  dir_down_d = adv_dir_down;
                  step_d     = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            HOLD: begin
               if (pending_q == CMD_START) begin
                  state_d = RUN;
               end else if (pending_q == CMD_HOME) begin
                  state_d    = IDLE;
                  idx_d      = '0;
                  cnt_d      = '0;
                  dir_down_d = 1'b0;
                  step_d     = (idx_q != '0);
               end
            end
            default: begin
               state_d = IDLE;
               idx_d   = '0;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Sequencer state registers.
   always_ff @(posedge vga_clk_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         pending_q  <= CMD_NONE;
         idx_q      <= '0;
         cnt_q      <= '0;
         dir_down_q <= 1'b0;
         step_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         dir_down_q <= dir_down_d;
         step_q     <= step_d;
      end
   end

   // Registered colour mux: the displayed frame's colour appears one cycle after the index.
   always_ff @(posedge vga_clk_i) begin
      if (reset_i) rgb_q <= '0;
      else         rgb_q <= slice[idx_q];
   end

   assign red_o       = rgb_q[11:8];
   assign green_o     = rgb_q[7:4];
   assign blue_o      = rgb_q[3:0];
   assign frame_idx_o = idx_q;
   assign step_o      = step_q;
   assign running_o   = (state_q == RUN);

endmodule
`default_nettype wire

// File: tb/tb_dog_anim_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dog_anim_sequencer
//  Description : Directed self-checking bench for dog_anim_sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dog_anim_sequencer;

   logic        clk = 1'b0;
   logic        rst_a, rst_b, vs;
   logic        start_a, stop_a, home_a, start_b;
   logic [71:0] rgb_in;
   logic [3:0]  red_a, green_a, blue_a, red_b, green_b, blue_b;
   logic [2:0]  idx_a, idx_b;
   logic        step_a, run_a, step_b, run_b;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   dog_anim_sequencer dut_a (
      .vga_clk_i   (clk),
      .reset_i     (rst_a),
      .vs_i        (vs),
      .start_i     (start_a),
      .stop_i      (stop_a),
      .home_i      (home_a),
      .rgb_in_i    (rgb_in),
      .red_o       (red_a),
      .green_o     (green_a),
      .blue_o      (blue_a),
      .frame_idx_o (idx_a),
      .step_o      (step_a),
      .running_o   (run_a)
   );

   dog_anim_sequencer #(.TICKS_PER_STEP(1), .PING_PONG(1'b1)) dut_b (
      .vga_clk_i   (clk),
      .reset_i     (rst_b),
      .vs_i        (vs),
      .start_i     (start_b),
      .stop_i      (1'b0),
      .home_i      (1'b0),
      .rgb_in_i    (rgb_in),
      .red_o       (red_b),
      .green_o     (green_b),
      .blue_o      (blue_b),
      .frame_idx_o (idx_b),
      .step_o      (step_b),
      .running_o   (run_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_a(input string tag, input int idx, input bit stp, input bit run);
      check({tag, ".idx"},  32'(idx_a),  32'(idx));
      check({tag, ".step"}, 32'(step_a), 32'(stp));
      check({tag, ".run"},  32'(run_a),  32'(run));
   endtask

   task automatic chk_rgb_a(input string tag, input logic [11:0] exp);
      check({tag, ".rgb"}, 32'({red_a, green_a, blue_a}), 32'(exp));
   endtask

   function automatic logic [11:0] frame_rgb(input int k);
      return 12'(12'h111 * (k + 1));
   endfunction

   // vs falls, tick is seen at the next posedge; returns just after that edge
   task automatic do_tick();
      @(negedge clk) vs = 1'b0;
      @(negedge clk) vs = 1'b1;
   endtask

   task automatic pulse_start();
      @(negedge clk) start_a = 1'b1;
      @(negedge clk) start_a = 1'b0;
   endtask

   task automatic pulse_stop();
      @(negedge clk) stop_a = 1'b1;
      @(negedge clk) stop_a = 1'b0;
   endtask

   task automatic pulse_home();
      @(negedge clk) home_a = 1'b1;
      @(negedge clk) home_a = 1'b0;
   endtask

   initial begin
      int pp_seq [12] = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1, 2};

      rst_a = 1'b1; rst_b = 1'b1; vs = 1'b1;
      start_a = 1'b0; stop_a = 1'b0; home_a = 1'b0; start_b = 1'b0;
      for (int k = 0; k < 6; k++) rgb_in[12*k +: 12] = frame_rgb(k);

      // ---- reset state ----
      repeat (2) @(negedge clk);
      chk_a("reset", 0, 1'b0, 1'b0);
      chk_rgb_a("reset", 12'h000);
      rst_a = 1'b0; rst_b = 1'b0;
      repeat (2) @(negedge clk);
      chk_rgb_a("idle_colour", frame_rgb(0));

      // ---- no start: three ticks stay idle on frame 0 ----
      for (int i = 0; i < 3; i++) do_tick();
      @(negedge clk);
      chk_a("idle3", 0, 1'b0, 1'b0);
      chk_rgb_a("idle3", frame_rgb(0));

      // ---- ping-pong instance, one tick per step ----
      @(negedge clk) start_b = 1'b1;
      @(negedge clk) start_b = 1'b0;
      do_tick();
      check("pp_start.run", 32'(run_b), 32'd1);
      check("pp_start.idx", 32'(idx_b), 32'd0);
      for (int i = 0; i < 12; i++) begin
         do_tick();
         check($sformatf("pp%0d.idx", i), 32'(idx_b), 32'(pp_seq[i]));
         check($sformatf("pp%0d.step", i), 32'(step_b), 32'd1);
      end

      // ---- default wrap mode, six ticks per step ----
      pulse_start();
      do_tick();
      chk_a("run_start", 0, 1'b0, 1'b1);
      for (int i = 1; i <= 36; i++) begin
         do_tick();
         chk_a($sformatf("wrap%0d", i), (i / 6) % 6, (i % 6) == 0, 1'b1);
         @(negedge clk);
         chk_rgb_a($sformatf("wrap%0d", i), frame_rgb((i / 6) % 6));
      end

      // ---- stop mid-step at frame 3, counter saved at 2 ----
      for (int i = 0; i < 18; i++) do_tick();
      chk_a("reach3", 3, 1'b1, 1'b1);
      do_tick();
      do_tick();
      pulse_stop();
      do_tick();
      chk_a("hold", 3, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         do_tick();
         chk_a($sformatf("hold%0d", i), 3, 1'b0, 1'b0);
      end
      pulse_start();
      do_tick();
      chk_a("resume", 3, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         do_tick();
         chk_a($sformatf("resume%0d", i), 3, 1'b0, 1'b1);
      end
      do_tick();
      chk_a("resume_step", 4, 1'b1, 1'b1);

      // ---- home from frame 4 ----
      pulse_home();
      do_tick();
      chk_a("home", 0, 1'b1, 1'b0);

      // ---- start and stop together while idle: stop wins ----
      @(negedge clk) begin start_a = 1'b1; stop_a = 1'b1; end
      @(negedge clk) begin start_a = 1'b0; stop_a = 1'b0; end
      do_tick();
      chk_a("startstop", 0, 1'b0, 1'b0);
      do_tick();
      chk_a("startstop2", 0, 1'b0, 1'b0);

      // ---- request in the tick cycle waits for the following tick ----
      @(negedge clk) begin vs = 1'b0; start_a = 1'b1; end
      @(negedge clk) begin vs = 1'b1; start_a = 1'b0; end
      chk_a("coincide", 0, 1'b0, 1'b0);
      do_tick();
      chk_a("coincide_next", 0, 1'b0, 1'b1);

      // ---- reset mid-run at frame 2 with START pending ----
      for (int i = 0; i < 12; i++) do_tick();
      chk_a("reach2", 2, 1'b1, 1'b1);
      pulse_start();
      @(negedge clk) rst_a = 1'b1;
      @(negedge clk) rst_a = 1'b0;
      chk_a("midreset", 0, 1'b0, 1'b0);
      chk_rgb_a("midreset", 12'h000);
      do_tick();
      chk_a("midreset_tick", 0, 1'b0, 1'b0);
      do_tick();
      chk_a("midreset_tick2", 0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
